// File: rtl/operand_fwd_ctrl.sv
// Registered ALU operand forwarding select and load-use stall control.
// Optional FWD_ZERO_REG_EN: register 0 is hardwired zero (never forwarded/stalled).
module operand_fwd_ctrl #(
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic [1:0]            sel_a,
    output logic [1:0]            sel_b,
    output logic                  stall
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } trk_t;

    trk_t       ex_q, mem_q, wb_q, ex_d;
    logic [1:0] sel_a_q, sel_a_d;
    logic [1:0] sel_b_q, sel_b_d;
    logic       accept;

    function automatic logic hit(trk_t e, logic [REG_ADDR_W-1:0] rs);
        logic h;
        h = e.valid && e.reg_write && (e.rd == rs);
`ifdef FWD_ZERO_REG_EN
        h = h && (rs != '0);
`else
        h = h;
`endif
        return h;
    endfunction

    // Nearest producer wins: EX, then MEM, then WB.
    function automatic logic [1:0] sel_f(logic [REG_ADDR_W-1:0] rs,
                                         trk_t ex, trk_t mem, trk_t wb);
        logic [1:0] s;
        if (hit(ex, rs))       s = 2'b01;
        else if (hit(mem, rs)) s = 2'b10;
        else if (hit(wb, rs))  s = 2'b11;
        else                   s = 2'b00;
        return s;
    endfunction

    always_comb begin
        stall   = id_valid && !flush && ex_q.mem_read &&
                  (hit(ex_q, id_rs1) || hit(ex_q, id_rs2));
        accept  = id_valid && !flush && !stall;
        ex_d    = '0;
        sel_a_d = 2'b00;
        sel_b_d = 2'b00;
        if (accept) begin
            ex_d.valid     = 1'b1;
            ex_d.rd        = id_rd;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
            sel_a_d        = sel_f(id_rs1, ex_q, mem_q, wb_q);
            sel_b_d        = sel_f(id_rs2, ex_q, mem_q, wb_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            sel_a_q <= 2'b00;
            sel_b_q <= 2'b00;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= ex_q;
            wb_q    <= mem_q;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
        end
    end

    assign sel_a = sel_a_q;
    assign sel_b = sel_b_q;

endmodule

// File: tb/tb_operand_fwd_ctrl.sv
// Directed table-driven bench for operand_fwd_ctrl.
// Expectations for register 0 follow FWD_ZERO_REG_EN.
module tb_operand_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [2:0] id_rs1, id_rs2, id_rd;
    logic       id_reg_write, id_mem_read, flush;
    logic [1:0] sel_a, sel_b;
    logic       stall;

    int checks = 0;
    int errors = 0;

`ifdef FWD_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    always #5 clk = ~clk;

    operand_fwd_ctrl #(.REG_ADDR_W(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .sel_a        (sel_a),
        .sel_b        (sel_b),
        .stall        (stall)
    );

    typedef struct {
        string      name;
        logic       v;
        logic [2:0] rs1, rs2, rd;
        logic       rw, mr, fl;
        logic       e_stall;
        logic [1:0] e_a, e_b;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(string nm, logic [1:0] act, logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic add(string nm, logic v, logic [2:0] rs1, logic [2:0] rs2,
                       logic [2:0] rd, logic rw, logic mr, logic fl,
                       logic es, logic [1:0] ea, logic [1:0] eb);
        vec_t r;
        r.name = nm; r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd;
        r.rw = rw; r.mr = mr; r.fl = fl;
        r.e_stall = es; r.e_a = ea; r.e_b = eb;
        tbl.push_back(r);
    endtask

    task automatic nops(int n);
        for (int i = 0; i < n; i++)
            add("nop", 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 0, 2'b00, 2'b00);
    endtask

    task automatic drive(logic v, logic [2:0] rs1, logic [2:0] rs2,
                         logic [2:0] rd, logic rw, logic mr, logic fl);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_reg_write = rw; id_mem_read = mr; flush = fl;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel_a", sel_a, 2'b00);
        chk("rst_sel_b", sel_b, 2'b00);
        chk("rst_stall", {1'b0, stall}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        // back-to-back ALU
        nops(3);
        add("b2b_i1", 1, 3'd1, 3'd1, 3'd3, 1, 0, 0, 0, 2'b00, 2'b00);
        add("b2b_i2", 1, 3'd3, 3'd6, 3'd7, 1, 0, 0, 0, 2'b01, 2'b00);
        // distance sweep
        for (int d = 1; d <= 3; d++) begin
            nops(3);
            add("dist_p", 1, 3'd1, 3'd1, 3'd5, 1, 0, 0, 0, 2'b00, 2'b00);
            for (int f = 0; f < d; f++)
                add("dist_f", 1, 3'd1, 3'd1, 3'd6, 1, 0, 0, 0, 2'b00, 2'b00);
            add($sformatf("dist%0d_c", d), 1, 3'd1, 3'd5, 3'd7, 1, 0, 0, 0,
                2'b00, (d == 1) ? 2'b10 : (d == 2) ? 2'b11 : 2'b00);
        end
        // load-use
        nops(3);
        add("lu_ld",   1, 3'd1, 3'd1, 3'd2, 1, 1, 0, 0, 2'b00, 2'b00);
        add("lu_stl",  1, 3'd2, 3'd3, 3'd4, 1, 0, 0, 1, 2'b00, 2'b00);
        add("lu_go",   1, 3'd2, 3'd3, 3'd4, 1, 0, 0, 0, 2'b10, 2'b00);
        // load-use on operand B only
        nops(3);
        add("lub_ld",  1, 3'd1, 3'd1, 3'd2, 1, 1, 0, 0, 2'b00, 2'b00);
        add("lub_stl", 1, 3'd5, 3'd2, 3'd4, 1, 0, 0, 1, 2'b00, 2'b00);
        add("lub_go",  1, 3'd5, 3'd2, 3'd4, 1, 0, 0, 0, 2'b00, 2'b10);
        // load followed by an unrelated consumer
        nops(3);
        add("lun_ld",  1, 3'd1, 3'd1, 3'd2, 1, 1, 0, 0, 2'b00, 2'b00);
        add("lun_c",   1, 3'd3, 3'd4, 3'd5, 1, 0, 0, 0, 2'b00, 2'b00);
        // priority
        nops(3);
        add("pri_i1",  1, 3'd1, 3'd1, 3'd4, 1, 0, 0, 0, 2'b00, 2'b00);
        add("pri_i2",  1, 3'd1, 3'd1, 3'd4, 1, 0, 0, 0, 2'b00, 2'b00);
        add("pri_i3",  1, 3'd4, 3'd4, 3'd6, 1, 0, 0, 0, 2'b01, 2'b01);
        // priority with flush on I3
        nops(3);
        add("prf_i1",  1, 3'd1, 3'd1, 3'd4, 1, 0, 0, 0, 2'b00, 2'b00);
        add("prf_i2",  1, 3'd1, 3'd1, 3'd4, 1, 0, 0, 0, 2'b00, 2'b00);
        add("prf_i3",  1, 3'd4, 3'd4, 3'd6, 1, 0, 1, 0, 2'b00, 2'b00);
        // flush beats load-use
        nops(3);
        add("fl_ld",   1, 3'd1, 3'd1, 3'd2, 1, 1, 0, 0, 2'b00, 2'b00);
        add("fl_c",    1, 3'd2, 3'd2, 3'd4, 1, 0, 1, 0, 2'b00, 2'b00);
        // invalid ID never stalls
        nops(3);
        add("iv_ld",   1, 3'd1, 3'd1, 3'd2, 1, 1, 0, 0, 2'b00, 2'b00);
        add("iv_c",    0, 3'd2, 3'd2, 3'd4, 1, 0, 0, 0, 2'b00, 2'b00);
        // zero register
        nops(3);
        add("z_i1",    1, 3'd1, 3'd1, 3'd0, 1, 0, 0, 0, 2'b00, 2'b00);
        add("z_i2",    1, 3'd0, 3'd1, 3'd7, 1, 0, 0, 0,
            ZR ? 2'b00 : 2'b01, 2'b00);
        nops(3);
        add("z_ld",    1, 3'd1, 3'd1, 3'd0, 1, 1, 0, 0, 2'b00, 2'b00);
        add("z_c",     1, 3'd0, 3'd1, 3'd7, 1, 0, 0, !ZR, 2'b00, 2'b00);
        nops(3);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].rd,
                  tbl[i].rw, tbl[i].mr, tbl[i].fl);
            #1;
            chk({tbl[i].name, "_stall"}, {1'b0, stall}, {1'b0, tbl[i].e_stall});
            @(posedge clk);
            #1;
            chk({tbl[i].name, "_sel_a"}, sel_a, tbl[i].e_a);
            chk({tbl[i].name, "_sel_b"}, sel_b, tbl[i].e_b);
        end

        // reset asserted in the middle of a stall
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, 0);
        end
        @(negedge clk);
        drive(1, 3'd1, 3'd1, 3'd2, 1, 1, 0);
        @(negedge clk);
        drive(1, 3'd2, 3'd3, 3'd4, 1, 0, 0);
        #1;
        chk("mrst_pre_stall", {1'b0, stall}, 2'b01);
        rst_n = 1'b0;
        #1;
        chk("mrst_stall", {1'b0, stall}, 2'b00);
        chk("mrst_sel_a", sel_a, 2'b00);
        chk("mrst_sel_b", sel_b, 2'b00);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_next_sel_a", sel_a, 2'b00);
        chk("mrst_next_sel_b", sel_b, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
